// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master round-robin bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1
    } arb_state_t;

    localparam int MASTER_COUNT = 2;
    localparam int WDT_WIDTH    = 16;

    function automatic logic [MASTER_COUNT-1:0] grantOf(arb_state_t state);
        logic [MASTER_COUNT-1:0] oneHot;
        oneHot = '0;
        if (state == GRANT0) oneHot = 2'b01;
        if (state == GRANT1) oneHot = 2'b10;
        return oneHot;
    endfunction

endpackage

// File: rtl/bus_arb_if.sv
// Bus handshake bundle: a master drives the request fields, a slave answers with rdata/ready/irq.
interface bus_arb_if;

    logic        valid;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  wstrobe;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;

    modport m (
        output valid, address, wdata, wstrobe,
        input  rdata, ready, irq
    );

    modport s (
        input  valid, address, wdata, wstrobe,
        output rdata, ready, irq
    );

endinterface

// File: rtl/bus_arb_watchdog.sv
// Grant watchdog: counts stalled grant cycles and flags the cycle in which the limit is reached.
module bus_arb_watchdog
    import bus_arb_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [WDT_WIDTH-1:0] count_q;
    logic [WDT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The count includes the current grant cycle, so LIMIT stalled cycles end on the LIMIT-th one.
    assign expired = !clear && (count_q == WDT_WIDTH'(LIMIT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin, non-preemptive arbiter sharing one slave.
// Optional grant watchdog is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    bus_arb_if.s                    m0,
    bus_arb_if.s                    m1,
    bus_arb_if.m                    sub,
    output logic [MASTER_COUNT-1:0] grant,
    output logic                    timeout
);

    if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
        $error("bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t state_q;
    arb_state_t state_d;
    logic       lastGrant_q;
    logic       lastGrant_d;
    logic       wdtHit;
    logic       wdtAbort;

`ifdef BUS_ARB_TIMEOUT_EN
    bus_arb_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) uWatchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q == IDLE),
        .run    ((state_q != IDLE) && !sub.ready),
        .expired(wdtHit)
    );
`else
    assign wdtHit = 1'b0;
`endif

    // A slave response in the expiry cycle takes priority over the abort.
    assign wdtAbort = wdtHit && !sub.ready;

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        unique case (state_q)
            IDLE: begin
                if (m0.valid && (!m1.valid || lastGrant_q)) begin
                    state_d = GRANT0;
                end else if (m1.valid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (!m0.valid || sub.ready || wdtAbort) begin
                    state_d     = IDLE;
                    lastGrant_d = 1'b0;
                end
            end
            GRANT1: begin
                if (!m1.valid || sub.ready || wdtAbort) begin
                    state_d     = IDLE;
                    lastGrant_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    // Only the owner sees the slave; a dropped valid gets no response forwarded.
    always_comb begin
        sub.valid   = 1'b0;
        sub.address = '0;
        sub.wdata   = '0;
        sub.wstrobe = '0;
        m0.ready    = 1'b0;
        m0.rdata    = '0;
        m1.ready    = 1'b0;
        m1.rdata    = '0;
        unique case (state_q)
            GRANT0: begin
                sub.valid   = m0.valid && !wdtHit;
                sub.address = m0.address;
                sub.wdata   = m0.wdata;
                sub.wstrobe = m0.wstrobe;
                m0.ready    = m0.valid && (sub.ready || wdtAbort);
                m0.rdata    = (m0.valid && !wdtAbort) ? sub.rdata : '0;
            end
            GRANT1: begin
                sub.valid   = m1.valid && !wdtHit;
                sub.address = m1.address;
                sub.wdata   = m1.wdata;
                sub.wstrobe = m1.wstrobe;
                m1.ready    = m1.valid && (sub.ready || wdtAbort);
                m1.rdata    = (m1.valid && !wdtAbort) ? sub.rdata : '0;
            end
            default: ;
        endcase
    end

    assign m0.irq  = sub.irq;
    assign m1.irq  = 1'b0;
    assign grant   = grantOf(state_q);
    assign timeout = wdtAbort;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: slave model with configurable wait states, one task per scenario.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  grant;
    logic        timeout;

    int          testsRun = 0;
    int          failCount = 0;

    int          slaveWait = 0;
    bit          slaveNever = 1'b0;
    logic [31:0] slaveRdata = 32'h0;
    int          waitCnt = 0;
    int          wrCount = 0;
    logic [31:0] wrAddr = 32'h0;
    logic [31:0] wrData = 32'h0;

    bus_arb_if m0If ();
    bus_arb_if m1If ();
    bus_arb_if subIf ();

    bus_arbiter #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .m0     (m0If),
        .m1     (m1If),
        .sub    (subIf),
        .grant  (grant),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Slave: ready after slaveWait stalled cycles, data bus always driven.
    always_comb begin
        subIf.ready = subIf.valid && !slaveNever && (waitCnt == slaveWait);
        subIf.rdata = slaveRdata;
    end

    always @(posedge clk) begin
        if (subIf.valid && !subIf.ready) waitCnt <= waitCnt + 1;
        else                             waitCnt <= 0;
        if (subIf.valid && subIf.ready && subIf.wstrobe != 4'h0) begin
            wrCount <= wrCount + 1;
            wrAddr  <= subIf.address;
            wrData  <= subIf.wdata;
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            testsRun++;
            if ((subIf.valid === 1'b1 && grant === 2'b00) || !$onehot0(grant)) begin
                failCount++;
                $display("[TB] FAIL invariant: grant=%b sub.valid=%b", grant, subIf.valid);
            end
        end
    end

    task automatic toPos();
        @(posedge clk);
        #1;
    endtask

    task automatic toNeg();
        @(negedge clk);
    endtask

    task automatic pulseReset();
        toPos();
        reset = 1'b0;
        toPos();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        toPos();
        toPos();
        toNeg();
        testsRun++;
        if (grant !== 2'b00 || timeout !== 1'b0 || subIf.valid !== 1'b0 ||
            m0If.ready !== 1'b0 || m1If.ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_state: grant=%b timeout=%b sub.valid=%b m0.ready=%b m1.ready=%b want 00 0 0 0 0",
                     grant, timeout, subIf.valid, m0If.ready, m1If.ready);
        end
        toPos();
        reset = 1'b1;
        toNeg();
        testsRun++;
        if (grant !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL reset_release_grant: got %b want 00", grant);
        end
    endtask

    task automatic test_single_write();
        toPos();
        slaveWait     = 0;
        subIf.irq     = 1'b1;
        m0If.valid    = 1'b1;
        m0If.address  = 32'h0000_0010;
        m0If.wdata    = 32'hDEAD_BEEF;
        m0If.wstrobe  = 4'hF;
        toNeg();
        testsRun++;
        if (grant !== 2'b00 || subIf.valid !== 1'b0 || m0If.ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL t1_latency: grant=%b sub.valid=%b m0.ready=%b want 00 0 0", grant, subIf.valid, m0If.ready);
        end
        testsRun++;
        if (m0If.irq !== 1'b1 || m1If.irq !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL t1_irq: m0.irq=%b m1.irq=%b want 1 0", m0If.irq, m1If.irq);
        end
        toPos();
        toNeg();
        testsRun++;
        if (grant !== 2'b01 || subIf.valid !== 1'b1 || subIf.address !== 32'h10 ||
            subIf.wdata !== 32'hDEAD_BEEF || subIf.wstrobe !== 4'hF) begin
            failCount++;
            $display("[TB] FAIL t1_forward: grant=%b valid=%b addr=%h wdata=%h strb=%h want 01 1 00000010 deadbeef f",
                     grant, subIf.valid, subIf.address, subIf.wdata, subIf.wstrobe);
        end
        testsRun++;
        if (m0If.ready !== 1'b1 || m1If.ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL t1_ready: m0.ready=%b m1.ready=%b want 1 0", m0If.ready, m1If.ready);
        end
        toPos();
        m0If.valid   = 1'b0;
        m0If.wstrobe = 4'h0;
        subIf.irq    = 1'b0;
        toNeg();
        testsRun++;
        if (grant !== 2'b00 || m0If.ready !== 1'b0 || wrCount !== 1 ||
            wrAddr !== 32'h10 || wrData !== 32'hDEAD_BEEF) begin
            failCount++;
            $display("[TB] FAIL t1_done: grant=%b m0.ready=%b writes=%0d addr=%h data=%h want 00 0 1 00000010 deadbeef",
                     grant, m0If.ready, wrCount, wrAddr, wrData);
        end
    endtask

    task automatic test_tie_after_reset();
        logic [7:0] seq;
        logic       m1ReadyEarly;
        logic       m1ReadyLate;
        pulseReset();
        toPos();
        m0If.valid   = 1'b1;
        m0If.address = 32'h20;
        m0If.wstrobe = 4'h0;
        m1If.valid   = 1'b1;
        m1If.address = 32'h24;
        m1If.wstrobe = 4'h0;
        toNeg(); seq[7:6] = grant; toPos();
        toNeg(); seq[5:4] = grant; m1ReadyEarly = m1If.ready; toPos();
        m0If.valid = 1'b0;
        toNeg(); seq[3:2] = grant; toPos();
        toNeg(); seq[1:0] = grant; m1ReadyLate = m1If.ready; toPos();
        m1If.valid = 1'b0;
        testsRun++;
        if (seq !== 8'b00_01_00_10) begin
            failCount++;
            $display("[TB] FAIL t2_grant_seq: got %b want 00010010", seq);
        end
        testsRun++;
        if (m1ReadyEarly !== 1'b0 || m1ReadyLate !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL t2_m1_ready: early=%b late=%b want 0 1", m1ReadyEarly, m1ReadyLate);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq;
        toPos();
        slaveRdata   = 32'h1234_5678;
        m0If.valid   = 1'b1;
        m0If.address = 32'h30;
        m0If.wdata   = 32'hA5A5_A5A5;
        m0If.wstrobe = 4'hF;
        m1If.valid   = 1'b1;
        m1If.address = 32'h100;
        m1If.wstrobe = 4'h0;
        seq = '0;
        for (int k = 0; k < 8; k++) begin
            toNeg();
            seq = {seq[13:0], grant};
            if (k == 3 || k == 7) begin
                testsRun++;
                if (m1If.ready !== 1'b1 || m1If.rdata !== 32'h1234_5678 ||
                    m0If.ready !== 1'b0 || m0If.rdata !== 32'h0) begin
                    failCount++;
                    $display("[TB] FAIL t3_m1_read k=%0d: m1.ready=%b m1.rdata=%h m0.ready=%b m0.rdata=%h want 1 12345678 0 0",
                             k, m1If.ready, m1If.rdata, m0If.ready, m0If.rdata);
                end
            end
            if (k == 1) begin
                testsRun++;
                if (m1If.ready !== 1'b0 || m1If.rdata !== 32'h0) begin
                    failCount++;
                    $display("[TB] FAIL t3_m1_nonowner: ready=%b rdata=%h want 0 0", m1If.ready, m1If.rdata);
                end
            end
            toPos();
        end
        m0If.valid   = 1'b0;
        m0If.wstrobe = 4'h0;
        m1If.valid   = 1'b0;
        testsRun++;
        if (seq !== 16'h1212) begin
            failCount++;
            $display("[TB] FAIL t3_alternate: got %b want 0001001000010010", seq);
        end
        testsRun++;
        if (wrCount !== 3 || wrData !== 32'hA5A5_A5A5) begin
            failCount++;
            $display("[TB] FAIL t3_writes: count=%0d data=%h want 3 a5a5a5a5", wrCount, wrData);
        end
    endtask

    task automatic test_no_preempt();
        logic [13:0] seq;
        logic        m0ReadyDuringWait;
        logic        m1ReadyOk;
        logic        m0ReadyFinal;
        toPos();
        slaveWait    = 3;
        m1If.valid   = 1'b1;
        m1If.address = 32'h104;
        m1If.wstrobe = 4'h0;
        seq = '0;
        m0ReadyDuringWait = 1'b0;
        m1ReadyOk = 1'b0;
        m0ReadyFinal = 1'b0;
        for (int k = 0; k < 7; k++) begin
            toNeg();
            seq = {seq[11:0], grant};
            if (k >= 1 && k <= 4) m0ReadyDuringWait = m0ReadyDuringWait | m0If.ready;
            if (k == 4) m1ReadyOk = m1If.ready & (m1If.rdata == 32'h1234_5678);
            if (k == 6) m0ReadyFinal = m0If.ready;
            toPos();
            if (k == 1) begin
                m0If.valid   = 1'b1;
                m0If.address = 32'h40;
                m0If.wdata   = 32'h0000_0011;
                m0If.wstrobe = 4'hF;
            end
            if (k == 4) begin
                m1If.valid = 1'b0;
                slaveWait  = 0;
            end
            if (k == 6) begin
                m0If.valid   = 1'b0;
                m0If.wstrobe = 4'h0;
            end
        end
        testsRun++;
        if (seq !== 14'b00_10_10_10_10_00_01) begin
            failCount++;
            $display("[TB] FAIL t4_grant_seq: got %b want 00101010100001", seq);
        end
        testsRun++;
        if (m0ReadyDuringWait !== 1'b0 || m1ReadyOk !== 1'b1 || m0ReadyFinal !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL t4_ready: m0_during_wait=%b m1_done=%b m0_final=%b want 0 1 1",
                     m0ReadyDuringWait, m1ReadyOk, m0ReadyFinal);
        end
    endtask

    task automatic test_reset_mid_transfer();
        toPos();
        slaveNever   = 1'b1;
        m1If.valid   = 1'b1;
        m1If.address = 32'h108;
        toNeg();
        toPos();
        toNeg();
        testsRun++;
        if (grant !== 2'b10 || subIf.valid !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL t5_stalled: grant=%b sub.valid=%b want 10 1", grant, subIf.valid);
        end
        #2;
        reset = 1'b0;
        #1;
        testsRun++;
        if (grant !== 2'b00 || subIf.valid !== 1'b0 || m1If.ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL t5_async_reset: grant=%b sub.valid=%b m1.ready=%b want 00 0 0",
                     grant, subIf.valid, m1If.ready);
        end
        slaveNever   = 1'b0;
        m0If.valid   = 1'b1;
        m0If.address = 32'h44;
        m0If.wstrobe = 4'h0;
        toPos();
        reset = 1'b1;
        toNeg();
        testsRun++;
        if (grant !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL t5_idle_after_release: got %b want 00", grant);
        end
        toPos();
        toNeg();
        testsRun++;
        if (grant !== 2'b01 || m0If.ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL t5_m0_wins_tie: grant=%b m0.ready=%b want 01 1", grant, m0If.ready);
        end
        toPos();
        m0If.valid = 1'b0;
        m1If.valid = 1'b0;
    endtask

    task automatic test_timeout();
        int pulses;
        logic m0ReadyEarly;
        pulses = 0;
        m0ReadyEarly = 1'b0;
        toPos();
        slaveNever   = 1'b1;
        m0If.valid   = 1'b1;
        m0If.address = 32'h50;
        m0If.wstrobe = 4'h0;
`ifdef BUS_ARB_TIMEOUT_EN
        toNeg();
        toPos();
        for (int k = 1; k <= 8; k++) begin
            toNeg();
            if (timeout === 1'b1) pulses++;
            if (k < 8) m0ReadyEarly = m0ReadyEarly | m0If.ready;
            if (k == 8) begin
                testsRun++;
                if (grant !== 2'b01 || m0If.ready !== 1'b1 || m0If.rdata !== 32'h0 ||
                    subIf.valid !== 1'b0 || timeout !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL t6_abort: grant=%b m0.ready=%b rdata=%h sub.valid=%b timeout=%b want 01 1 0 0 1",
                             grant, m0If.ready, m0If.rdata, subIf.valid, timeout);
                end
            end
            toPos();
        end
        m0If.valid = 1'b0;
        slaveNever = 1'b0;
        toNeg();
        if (timeout === 1'b1) pulses++;
        testsRun++;
        if (grant !== 2'b00 || pulses !== 1 || m0ReadyEarly !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL t6_after_abort: grant=%b pulses=%0d early_ready=%b want 00 1 0",
                     grant, pulses, m0ReadyEarly);
        end
`else
        for (int k = 0; k < 100; k++) begin
            toNeg();
            if (timeout !== 1'b0) pulses++;
            m0ReadyEarly = m0ReadyEarly | m0If.ready;
            toPos();
        end
        toNeg();
        testsRun++;
        if (grant !== 2'b01 || subIf.valid !== 1'b1 || m0ReadyEarly !== 1'b0 ||
            pulses !== 0 || timeout !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL t6_still_waiting: grant=%b sub.valid=%b ready_seen=%b timeout_pulses=%0d want 01 1 0 0",
                     grant, subIf.valid, m0ReadyEarly, pulses);
        end
        m0If.valid = 1'b0;
        slaveNever = 1'b0;
        pulseReset();
        toNeg();
        testsRun++;
        if (grant !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL t6_recover: got %b want 00", grant);
        end
`endif
    endtask

    initial begin
        m0If.valid    = 1'b0;
        m0If.address  = 32'h0;
        m0If.wdata    = 32'h0;
        m0If.wstrobe  = 4'h0;
        m1If.valid    = 1'b0;
        m1If.address  = 32'h0;
        m1If.wdata    = 32'h0;
        m1If.wstrobe  = 4'h0;
        subIf.irq     = 1'b0;
        test_reset();
        test_single_write();
        test_tie_after_reset();
        test_back_to_back();
        test_no_preempt();
        test_reset_mid_transfer();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
